uart_tx_framer: RTL

- Parametrised transmit serializer: the next generation of the plain 8-bit PISO shifter.
- Accepts a parallel word through a valid/ready handshake and emits one complete UART frame: start bit, data bits, optional parity, then 1 or 2 stop bits.
- Emits one bit per slow_baud_clk cycle on a registered, idle-high line.
- Sits between the TX holding logic and the pad; the baud-rate divider that produces slow_baud_clk is upstream.

---
 rtl/uart_tx_framer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_framer.sv
// UART transmit framer: parallel word in through valid/ready,
// one start/data/parity/stop frame out, one bit per baud clock.
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  slow_baud_clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx_serial,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
  localparam logic ODD = 1'(PARITY_ODD);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_framer: STOP_BITS must be 1 or 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("uart_tx_framer: DATA_WIDTH must be 5..9");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  par_q, par_d;
  logic                  serial_d;
  logic                  last_stop;
  logic                  accept;
  logic                  out_bit;
  logic [DATA_WIDTH-1:0] shifted;

  if (MSB_FIRST != 0) begin : g_msb
    assign out_bit = shreg_q[DATA_WIDTH-1];
    assign shifted = {shreg_q[DATA_WIDTH-2:0], 1'b0};
  end else begin : g_lsb
    assign out_bit = shreg_q[0];
    assign shifted = {1'b0, shreg_q[DATA_WIDTH-1:1]};
  end

  assign last_stop = (state_q == STOP) && (cnt_q == LAST_STOP);
  assign tx_ready  = (state_q == IDLE) || last_stop;
  assign tx_done   = last_stop;
  assign busy      = (state_q != IDLE);
  assign accept    = tx_valid && tx_ready;

  // serial_d is the line value for the cycle after the edge,
  // so an accept puts the start bit out on that same edge.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    serial_d = tx_serial;
    unique case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        if (accept) begin
          state_d  = START;
          serial_d = 1'b0;
          shreg_d  = tx_data;
          par_d    = ^tx_data;
          cnt_d    = '0;
        end
      end
      START: begin
        state_d  = DATA;
        serial_d = out_bit;
        shreg_d  = shifted;
        cnt_d    = '0;
      end
      DATA: begin
        if (cnt_q == LAST_DATA) begin
          cnt_d = '0;
          if (PARITY_EN != 0) begin
            state_d  = PARITY;
            serial_d = par_q ^ ODD;
          end else begin
            state_d  = STOP;
            serial_d = 1'b1;
          end
        end else begin
          serial_d = out_bit;
          shreg_d  = shifted;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        state_d  = STOP;
        serial_d = 1'b1;
        cnt_d    = '0;
      end
      STOP: begin
        serial_d = 1'b1;
        if (!last_stop) begin
          cnt_d = cnt_q + 1'b1;
        end else if (accept) begin
          state_d  = START;
          serial_d = 1'b0;
          shreg_d  = tx_data;
          par_d    = ^tx_data;
          cnt_d    = '0;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          shreg_d = '0;
          par_d   = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge slow_baud_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      par_q     <= 1'b0;
      tx_serial <= 1'b1;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      par_q     <= par_d;
      tx_serial <= serial_d;
    end
  end

endmodule
